// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  input  logic                  mthi_i,
  input  logic                  mtlo_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                  r_state, w_next;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_is_div, r_neg_q, r_neg_r, r_dbz;
  logic [DATA_WIDTH-1:0]   r_m, r_acc_hi, r_acc_lo, r_hi, r_lo;

  logic                    w_start, w_div, w_signed, w_a_neg, w_b_neg, w_b_zero;
  logic [DATA_WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [DATA_WIDTH:0]     w_add, w_shift, w_diff;
  logic [2*DATA_WIDTH-1:0] w_prod_neg;

  assign w_start  = (r_state == S_IDLE) && start_i && !flush_i;
  assign w_div    = op_i[1];
  assign w_signed = ~op_i[0];
  assign w_a_neg  = w_signed & a_i[DATA_WIDTH-1];
  assign w_b_neg  = w_signed & b_i[DATA_WIDTH-1];
  assign w_a_abs  = w_a_neg ? -a_i : a_i;
  assign w_b_abs  = w_b_neg ? -b_i : b_i;
  assign w_b_zero = (b_i == '0);

  // Multiply: {acc_hi, acc_lo} holds partial product with the multiplier shifting out of acc_lo.
  // Divide: acc_hi is the partial remainder, quotient bits shift into acc_lo.
  assign w_add      = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_m} : '0);
  assign w_shift    = {r_acc_hi, r_acc_lo[DATA_WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_m};
  assign w_prod_neg = -{r_acc_hi, r_acc_lo};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = (w_div && w_b_zero) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_m      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_is_div <= w_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dbz    <= w_div && w_b_zero;
            r_cnt    <= CNT_WIDTH'(DATA_WIDTH - 1);
            if (w_div && w_b_zero) begin
              r_acc_hi <= a_i;
              r_acc_lo <= '1;
            end else begin
              r_m      <= w_div ? w_b_abs : w_a_abs;
              r_acc_hi <= '0;
              r_acc_lo <= w_div ? w_a_abs : w_b_abs;
            end
          end else if (!start_i) begin
            if (mthi_i) r_hi <= wr_data_i;
            if (mtlo_i) r_lo <= wr_data_i;
          end
        end
        S_CALC: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          if (r_is_div) begin
            if (!w_diff[DATA_WIDTH]) begin
              r_acc_hi <= w_diff[DATA_WIDTH-1:0];
              r_acc_lo <= {r_acc_lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
              r_acc_hi <= w_shift[DATA_WIDTH-1:0];
              r_acc_lo <= {r_acc_lo[DATA_WIDTH-2:0], 1'b0};
            end
          end else begin
            {r_acc_hi, r_acc_lo} <= {w_add, r_acc_lo[DATA_WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (!r_is_div) begin
            if (r_neg_q) {r_acc_hi, r_acc_lo} <= w_prod_neg;
          end else begin
            if (r_neg_q) r_acc_lo <= -r_acc_lo;
            if (r_neg_r) r_acc_hi <= -r_acc_hi;
          end
        end
        S_DONE: begin
          if (flush_i) begin
            r_dbz <= 1'b0;
          end else begin
            r_hi <= r_acc_hi;
            r_lo <= r_acc_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (r_state == S_CALC) || (r_state == S_FIX);
  assign done_o        = (r_state == S_DONE) && !flush_i;
  assign div_by_zero_o = r_dbz;
  assign hi_o          = r_hi;
  assign lo_o          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, flush_i, mthi_i, mtlo_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i, wr_data_i;
  logic        busy_o, done_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;

  int n_assert = 0;
  int n_fail   = 0;

  mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wr_data_i(wr_data_i),
    .busy_o(busy_o), .done_o(done_o), .div_by_zero_o(div_by_zero_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic (division truncates toward zero).
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    dbz = 1'b0;
    hi = '0;
    lo = '0;
    if (op[1] && b == 32'd0) begin
      dbz = 1'b1;
      hi  = a;
      lo  = 32'hFFFF_FFFF;
    end else begin
      case (op)
        2'b00: begin p = longint'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
        2'b01: begin p = ua * ub;           hi = p[63:32]; lo = p[31:0]; end
        2'b10: begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
        default: begin p = ua / ub; hi = 32'(ua % ub); lo = p[31:0]; end
      endcase
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] eh, el;
    logic        ed;
    int          cyc, bcnt;
    model(op, a, b, eh, el, ed);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    bcnt = 0;
    while (done_o !== 1'b1 && cyc < 100) begin
      if (busy_o === 1'b1) bcnt++;
      start_i = 1'($urandom_range(0, 1));
      op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
      mthi_i = 1'($urandom_range(0, 1)); mtlo_i = 1'($urandom_range(0, 1));
      wr_data_i = $urandom;
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
    check({tag, " latency"}, 64'(cyc), ed ? 64'd1 : 64'd34);
    check({tag, " busy cycles"}, 64'(bcnt), ed ? 64'd0 : 64'd33);
    check({tag, " busy at done"}, 64'(busy_o), 64'd0);
    check({tag, " dbz at done"}, 64'(div_by_zero_o), 64'(ed));
    @(negedge clk);
    check({tag, " hi"}, 64'(hi_o), 64'(eh));
    check({tag, " lo"}, 64'(lo_o), 64'(el));
    check({tag, " dbz after"}, 64'(div_by_zero_o), 64'(ed));
    check({tag, " done one pulse"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int dcnt;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b0; start_i = 1'b0; flush_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
    op_i = 2'b00; a_i = '0; b_i = '0; wr_data_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    check("reset dbz", 64'(div_by_zero_o), 64'd0);
    reset = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, "mult -3x5");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    run_op(2'b11, 32'd100, 32'd0, "divu by zero");
    run_op(2'b01, 32'd2, 32'd3, "multu 2x3");

    @(negedge clk); mthi_i = 1'b1; mtlo_i = 1'b1; wr_data_i = 32'h0000_ABCD;
    @(negedge clk); mtlo_i = 1'b0; wr_data_i = 32'h0000_1234;
    @(negedge clk); mthi_i = 1'b0;
    check("mthi+mtlo lo", 64'(lo_o), 64'h0000_ABCD);
    check("mthi hi", 64'(hi_o), 64'h0000_1234);

    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; a_i = 32'd7; b_i = 32'd6;
    @(negedge clk); start_i = 1'b0; flush_i = 1'b0;
    check("flush suppresses start", 64'(busy_o), 64'd0);

    start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    dcnt = 0;
    for (int c = 1; c < 10; c++) begin
      if (done_o === 1'b1) dcnt++;
      start_i = (c == 5);
      a_i = 32'd9; b_i = 32'd9;
      @(negedge clk);
    end
    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk); start_i = 1'b0; flush_i = 1'b0;
    check("flush busy low", 64'(busy_o), 64'd0);
    for (int c = 0; c < 40; c++) begin
      if (done_o === 1'b1) dcnt++;
      @(negedge clk);
    end
    check("flush no done", 64'(dcnt), 64'd0);
    check("flush hi kept", 64'(hi_o), 64'h0000_1234);
    check("flush lo kept", 64'(lo_o), 64'h0000_ABCD);

    start_i = 1'b1; op_i = 2'b01; a_i = 32'd3; b_i = 32'd3;
    @(negedge clk); start_i = 1'b0;
    dcnt = 0;
    while (done_o !== 1'b1 && dcnt < 100) begin
      @(negedge clk);
      dcnt++;
    end
    check("flush-at-done reached done", 64'(done_o), 64'd1);
    flush_i = 1'b1;
    #1;
    check("flush-at-done masks done", 64'(done_o), 64'd0);
    @(negedge clk); flush_i = 1'b0;
    check("flush-at-done hi", 64'(hi_o), 64'h0000_1234);
    check("flush-at-done lo", 64'(lo_o), 64'h0000_ABCD);

    start_i = 1'b1; op_i = 2'b11; a_i = $urandom; b_i = 32'd7;
    @(negedge clk); start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async reset hi", 64'(hi_o), 64'd0);
    check("async reset lo", 64'(lo_o), 64'd0);
    check("async reset busy", 64'(busy_o), 64'd0);
    @(negedge clk); reset = 1'b1;

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) rb = -rb;
      run_op(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
